// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
//   Shares one 16-bit serial divider among NUM_REQ requesters. A round-robin
//   grant picks one pending request, the operands go to the divider with a
//   one-cycle start pulse, and the result comes back on a single response
//   channel tagged with the requester index. Divide-by-zero is answered at
//   once without the divider. A watchdog aborts the operation with an error
//   if the divider never signals done.
//
// Ports
//   clk, rst_n                  clock and synchronous active-low reset
//   req_valid / req_ready       per-requester handshake (ready is one-hot or 0)
//   req_dividend / req_divisor  flattened 16-bit operands, requester i at [16i+:16]
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      index of the requester owning the response
//   rsp_quotient/rsp_remainder  result (0/0 on timeout, FFFF/dividend on dbz)
//   rsp_dbz, rsp_err            divide-by-zero and timeout flags
//   div_start                   one-cycle start pulse to the divider
//   div_dividend / div_divisor  divider operands, held from start until done
//   div_done                    divider completion pulse
//   div_quotient/div_remainder  divider result, valid with div_done
// -----------------------------------------------------------------------------
module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_dividend,
    input  logic [16*NUM_REQ-1:0] req_divisor,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_quotient,
    output logic [15:0]           rsp_remainder,
    output logic                  rsp_dbz,
    output logic                  rsp_err,
    output logic                  div_start,
    output logic [15:0]           div_dividend,
    output logic [15:0]           div_divisor,
    input  logic                  div_done,
    input  logic [15:0]           div_quotient,
    input  logic [15:0]           div_remainder
);

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [IDW-1:0] rr_last;
    logic [IDW-1:0] grant;
    logic           grant_found;
    logic           accept;
    logic [15:0]    sel_dividend;
    logic [15:0]    sel_divisor;
    logic [WDW-1:0] wd;
    logic           wd_expired;

    // Round-robin scan starting just after the last granted requester.
    // NOTE: every variable assigned in an always_comb gets a default at the
    // top of the block, so no path leaves it unassigned and no latch is built.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = IDW'(idx);
            end
        end
    end

    assign sel_dividend = req_dividend[16*int'(grant) +: 16];
    assign sel_divisor  = req_divisor[16*int'(grant) +: 16];
    assign wd_expired   = (wd == WDW'(TIMEOUT - 1));
    assign rsp_valid    = (state == RESP);

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n)
            req_ready[grant] = 1'b1;
    end

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and control outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    state_next = (sel_divisor == 16'd0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                div_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (div_done || wd_expired)
                    state_next = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, round-robin pointer, watchdog and response.
    // NOTE: every datapath register is reset (there is no storage array here),
    // so outputs have defined values straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last       <= IDW'(NUM_REQ - 1);
            div_dividend  <= '0;
            div_divisor   <= '0;
            wd            <= '0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        rsp_id       <= grant;
                        rr_last      <= grant;
                        if (sel_divisor == 16'd0) begin
                            rsp_quotient  <= 16'hFFFF;
                            rsp_remainder <= sel_dividend;
                            rsp_dbz       <= 1'b1;
                            rsp_err       <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    wd <= '0;
                end
                WAIT: begin
                    // done wins over a coincident watchdog expiry.
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_dbz       <= 1'b0;
                        rsp_err       <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_dbz       <= 1'b0;
                        rsp_err       <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_share_arbiter
//   Self-checking bench for div_share_arbiter. A behavioural divider answers
//   17 edges after it samples start (or never, in hang mode). Expected grant
//   order and results come from a round-robin scan over the current request
//   mask and plain arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_div_share_arbiter;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;
    localparam int DIV_LAT = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [16*N-1:0]   req_dividend;
    logic [16*N-1:0]   req_divisor;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_quotient;
    logic [15:0]       rsp_remainder;
    logic              rsp_dbz;
    logic              rsp_err;
    logic              div_start;
    logic [15:0]       div_dividend;
    logic [15:0]       div_divisor;
    logic              div_done;
    logic [15:0]       div_quotient;
    logic [15:0]       div_remainder;

    logic [15:0] dvd [N];
    logic [15:0] dvs [N];
    logic        hang;
    logic        stray;
    int          cnt;
    int          tb_rr;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_dividend[16*i +: 16] = dvd[i];
            req_divisor[16*i +: 16]  = dvs[i];
        end
    end

    div_share_arbiter #(.NUM_REQ(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_dbz       (rsp_dbz),
        .rsp_err       (rsp_err),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Behavioural divider: result appears DIV_LAT edges after start is sampled,
    // computed from the operands present at that time.
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (!rst_n) begin
            cnt <= 0;
        end else if (div_start) begin
            cnt <= DIV_LAT;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !hang) begin
                div_done      <= 1'b1;
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
            end
        end
        if (stray) begin
            div_done      <= 1'b1;
            div_quotient  <= 16'hDEAD;
            div_remainder <= 16'hBEEF;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // First requester with valid set, scanning onward from the last one served.
    function automatic int exp_grant(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(tb_rr + k) % N]) return (tb_rr + k) % N;
        return -1;
    endfunction

    // One full operation. Called shortly after an edge with requests set up.
    task automatic run_one(input string tag, input bit keep, input int hold, input bit exp_err);
        int          id, lat, starts, exp_lat;
        logic [15:0] a, b, eq, er;
        logic        edbz;
        logic [63:0] snap;
        id = exp_grant(req_valid);
        if (id < 0) id = 0;
        a    = dvd[id];
        b    = dvs[id];
        edbz = (b == 16'd0) && !exp_err;
        if (exp_err) begin
            eq = 16'd0; er = 16'd0; exp_lat = 1 + TIMEOUT;
        end else if (b == 16'd0) begin
            eq = 16'hFFFF; er = a; exp_lat = 0;
        end else begin
            eq = a / b; er = a % b; exp_lat = 1 + DIV_LAT + 1;
        end
        #1;
        check({tag, " ready"}, 64'(req_ready), 64'(1) << id);
        @(posedge clk); #1;
        if (!keep) req_valid[id] = 1'b0;
        lat = 0; starts = 0;
        while (!rsp_valid && lat < 200) begin
            if (div_start) starts++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " starts"},  64'(starts), (edbz ? 64'd0 : 64'd1));
        check({tag, " id"},      64'(rsp_id), 64'(id));
        check({tag, " quot"},    64'(rsp_quotient), 64'(eq));
        check({tag, " rem"},     64'(rsp_remainder), 64'(er));
        check({tag, " dbz/err"}, 64'({rsp_dbz, rsp_err}), 64'({edbz, exp_err}));
        snap = 64'({rsp_quotient, rsp_remainder, 8'(rsp_id), rsp_valid, rsp_dbz, rsp_err});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold rsp"},
                  64'({rsp_quotient, rsp_remainder, 8'(rsp_id), rsp_valid, rsp_dbz, rsp_err}), snap);
            check({tag, " hold ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " rsp drop"}, 64'(rsp_valid), 64'd0);
        tb_rr = id;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        tests = 0; fails = 0;
        hang = 1'b0; stray = 1'b0;
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin dvd[i] = 16'(i + 1); dvs[i] = 16'(i + 2); end
        tb_rr = N - 1;

        // Reset values, with every request valid while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst ready",   64'(req_ready), 64'd0);
        check("rst outputs", 64'({rsp_valid, rsp_dbz, rsp_err, div_start}), 64'd0);
        check("rst rsp",     64'({8'(rsp_id), rsp_quotient, rsp_remainder}), 64'd0);
        check("rst div ops", 64'({div_dividend, div_divisor}), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic divide on requester 0.
        dvd[0] = 16'd100; dvs[0] = 16'd7; req_valid = 4'b0001;
        run_one("basic", 1'b0, 0, 1'b0);

        // Divide by zero on requester 1.
        dvd[1] = 16'd1234; dvs[1] = 16'd0; req_valid = 4'b0010;
        run_one("dbz", 1'b0, 0, 1'b0);

        // Backpressure on the response while others wait, then rr order resumes.
        dvd[0] = 16'd4000; dvs[0] = 16'd3;
        dvd[2] = 16'd999;  dvs[2] = 16'd10;
        dvd[3] = 16'd65535; dvs[3] = 16'd1;
        req_valid = 4'b1101;
        run_one("hold", 1'b0, 10, 1'b0);
        run_one("after hold", 1'b0, 0, 1'b0);

        // Divider never answers: watchdog abort on requester 0.
        hang = 1'b1;
        run_one("timeout", 1'b0, 0, 1'b1);
        hang = 1'b0;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        check("stray ignored", 64'(rsp_valid), 64'd0);
        dvd[1] = 16'd65535; dvs[1] = 16'd255; req_valid = 4'b0010;
        run_one("post timeout", 1'b0, 0, 1'b0);

        // Randomized traffic with random masks and some zero divisors.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                dvd[i] = 16'($urandom);
                dvs[i] = ($urandom_range(0, 3) == 0) ? 16'd0 :
                         (($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom));
                if (dvs[i] == 16'd0 && $urandom_range(0, 3) != 0) dvs[i] = 16'd1;
            end
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            run_one("random", 1'b0, $urandom_range(0, 2), 1'b0);
        end
        req_valid = '0;

        // Reset in the middle of WAIT.
        dvd[0] = 16'd500; dvs[0] = 16'd5; req_valid = 4'b0001;
        #1;
        check("midrst ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst gated ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("midrst outputs", 64'({rsp_valid, rsp_dbz, rsp_err, div_start}), 64'd0);
        check("midrst rsp",     64'({8'(rsp_id), rsp_quotient, rsp_remainder}), 64'd0);
        check("midrst div ops", 64'({div_dividend, div_divisor}), 64'd0);
        rst_n = 1'b1;
        tb_rr = N - 1;
        req_valid = '0;
        @(posedge clk); #1;

        // All requesters valid continuously: expected order 0,1,2,3,0.
        dvd[0] = 16'd100;  dvs[0] = 16'd7;
        dvd[1] = 16'd2000; dvs[1] = 16'd13;
        dvd[2] = 16'd77;   dvs[2] = 16'd0;
        dvd[3] = 16'd5;    dvs[3] = 16'd9;
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            check("fair order", 64'(exp_grant(req_valid)), 64'(n % N));
            run_one("fair", 1'b1, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
